// File: rtl/shared_net_arbiter_pkg.sv
// Shared definitions for the shared-net arbiter: FSM state encoding,
// the default idle level of the net and the width helpers.
package shared_net_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Width of a requester index.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_hold without wrapping.
    function automatic int hold_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/shared_net_arbiter_rr_priority_pick.sv
// Combinational round-robin winner search: starts one past the last owner
// and returns the first requester found while moving upward (modulo N_REQ).
module rr_priority_pick
    import shared_net_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [id_width(N_REQ)-1:0] last_owner,
    output logic [id_width(N_REQ)-1:0] winner,
    output logic                       found
);

    localparam int ID_W = id_width(N_REQ);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no
        // path through the block leaves a value unassigned (no latch).
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            int cand;
            cand = (int'(last_owner) + off) % N_REQ;
            if (!found && req[ID_W'(cand)]) begin
                found  = 1'b1;
                winner = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_net_arbiter.sv
// Round-robin owner of a single shared net: one registered driver at a time,
// bounded hold time and a one-cycle undriven turnaround between owners.
module shared_net_arbiter
    import shared_net_arbiter_pkg::*;
#(
    parameter int   N_REQ      = 4,
    parameter int   MAX_HOLD   = 8,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           din,
    output logic [N_REQ-1:0]           gnt,
    output logic [id_width(N_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       shared_net
);

    localparam int ID_W   = id_width(N_REQ);
    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            state;
    logic [ID_W-1:0]   last_owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic              release_now;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner),
        .found      (found)
    );

    // The owner leaves when it stops asking or when its hold budget is spent.
    assign release_now = !req[owner_id] || (hold_cnt == HOLD_MAX);

    // NOTE: state and output registers use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            owner_id   <= '0;
            last_owner <= ID_W'(N_REQ - 1);
            hold_cnt   <= '0;
            shared_net <= IDLE_LEVEL;
        end else begin
            case (state)
                // Arbitration happens both from IDLE and during the turnaround.
                ST_IDLE, ST_TURN: begin
                    shared_net <= IDLE_LEVEL;
                    if (found) begin
                        state      <= ST_GRANT;
                        gnt        <= N_REQ'(1) << winner;
                        busy       <= 1'b1;
                        owner_id   <= winner;
                        last_owner <= winner;
                        hold_cnt   <= HOLD_W'(1);
                    end else begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    if (release_now) begin
                        state      <= ST_TURN;
                        gnt        <= '0;
                        busy       <= 1'b0;
                        shared_net <= IDLE_LEVEL;
                    end else begin
                        shared_net <= din[owner_id];
                        if (hold_cnt < HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    gnt        <= '0;
                    busy       <= 1'b0;
                    shared_net <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Directed self-checking bench for shared_net_arbiter (N_REQ=4, MAX_HOLD=8,
// IDLE_LEVEL=0); inputs change and outputs are sampled on the falling edge.
module tb_shared_net_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] owner_id;
    logic       busy;
    logic       shared_net;

    int checks   = 0;
    int failures = 0;

    shared_net_arbiter #(
        .N_REQ      (4),
        .MAX_HOLD   (8),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .owner_id   (owner_id),
        .busy       (busy),
        .shared_net (shared_net)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".net"}, 32'(shared_net), 32'h0);
    endtask

    // Eight grant cycles for owner e followed by one TURN cycle.
    task automatic full_hold(input int e, input string tag);
        for (int c = 0; c < 8; c++) begin
            step();
            check({tag, ".gnt"}, 32'(gnt), 32'(1) << e);
            check({tag, ".owner"}, 32'(owner_id), 32'(e));
            if (c == 0) check({tag, ".net_first"}, 32'(shared_net), 32'h0);
            if (c == 1) check({tag, ".net_data"}, 32'(shared_net), 32'(din[e]));
        end
        step();
        check_idle_out({tag, ".turn"});
    endtask

    initial begin
        logic [3:0] pattern;
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = 4'b0000;
        @(negedge clk);
        step();
        step();
        check_idle_out("reset");
        check("reset.owner", 32'(owner_id), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle.gnt", 32'(gnt), 32'h0);

        // Single request with din[2] toggling; net lags din by one cycle.
        req = 4'b0100;
        step();
        check("single.gnt", 32'(gnt), 32'h4);
        check("single.owner", 32'(owner_id), 32'h2);
        check("single.busy", 32'(busy), 32'h1);
        check("single.net0", 32'(shared_net), 32'h0);
        pattern = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            din[2] = pattern[i];
            step();
            check("single.net", 32'(shared_net), 32'(pattern[i]));
        end
        req = 4'b0000;
        step();
        check_idle_out("single.turn");
        check("single.owner_kept", 32'(owner_id), 32'h2);
        step();
        check("single.idle", 32'(gnt), 32'h0);

        // Early release: owner 1 drops after 3 cycles, req[3] already waiting.
        din = 4'b0000;
        req = 4'b0010;
        step();
        check("early.gnt1", 32'(gnt), 32'h2);
        req = 4'b1010;
        step();
        check("early.ignore", 32'(gnt), 32'h2);
        step();
        check("early.gnt3rd", 32'(gnt), 32'h2);
        req = 4'b1000;
        step();
        check_idle_out("early.turn");
        step();
        check("early.next", 32'(gnt), 32'h8);
        check("early.owner", 32'(owner_id), 32'h3);
        req = 4'b0000;
        step();
        step();

        // Round-robin with all requesting: 0,1,2,3,0, each for MAX_HOLD cycles.
        din = 4'b1111;
        req = 4'b1111;
        full_hold(0, "rr0");
        full_hold(1, "rr1");
        full_hold(2, "rr2");
        full_hold(3, "rr3");
        full_hold(0, "rr4");
        req = 4'b0000;
        step();
        check("rr.idle", 32'(gnt), 32'h0);

        // Lone hog: requester 0 alone keeps winning after each turnaround.
        req = 4'b0001;
        full_hold(0, "hog_a");
        full_hold(0, "hog_b");
        step();
        check("hog.regrant", 32'(gnt), 32'h1);

        // Drop coinciding with the hold limit: single TURN, then new owner.
        for (int c = 0; c < 7; c++) step();
        check("lim.gnt8", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check_idle_out("lim.turn");
        req = 4'b0010;
        step();
        check("lim.next", 32'(gnt), 32'h2);
        check("lim.owner", 32'(owner_id), 32'h1);
        req = 4'b0000;
        step();
        step();

        // Reset while owner 2 drives a 1 onto the net.
        din = 4'b0100;
        req = 4'b0100;
        step();
        check("rst.gnt", 32'(gnt), 32'h4);
        step();
        check("rst.net_hi", 32'(shared_net), 32'h1);
        rst_n = 1'b0;
        step();
        check_idle_out("rst.after");
        check("rst.owner", 32'(owner_id), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        check("rst.first", 32'(gnt), 32'h1);
        check("rst.first_owner", 32'(owner_id), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
